alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 8..64, power of two.
REQ-002 Parameter CNT_W, default 32, width of every statistics counter.
REQ-003 Derived SHAMT_W = log2(WIDTH); not overridable.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 inValid  input  1  upstream presents an operation.
REQ-007 inReady  output  1  block can accept an operation this cycle.
REQ-008 operandA, operandB  input  WIDTH each  operands.
REQ-009 op  input  4  opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9; 10..15 illegal.
REQ-010 outValid  output  1  result, flags and power are valid.
REQ-011 outReady  input  1  downstream takes the result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 flagZero, flagNeg, flagCarry, flagOverflow  output  1 each  result flags.
REQ-014 errIllegal  output  1  the presented result came from an illegal opcode.
REQ-015 clearStats  input  1  synchronous clear of all statistics.
REQ-016 operationTotal  output  CNT_W  count of accepted legal operations.
REQ-017 operationMostUsed  output  4  opcode with the highest count.
REQ-018 estimatedPower  output  8  power cost of the operation in the output stage.
REQ-019 operationActive  output  1  at least one pipeline stage holds an operation.

Function
REQ-020 Two register stages: S1 (operands and op), then S2 (result, flags, power, errIllegal).
REQ-021 s2Adv = !S2valid || outReady; inReady = !S1valid || s2Adv, combinational.
REQ-022 Acceptance is inValid && inReady at a rising edge, which loads S1.
REQ-023 S1 moves to S2 when S1valid && s2Adv.
REQ-024 Latency: an operation accepted at edge k shows outValid=1 after edge k+1 when outReady does not stall.
REQ-025 Throughput is one operation per cycle while outReady=1.
REQ-026 While outValid=1 && outReady=0, every S2 output holds stable.
REQ-027 While outValid=1 && outReady=0, S1 holds and inReady = !S1valid.
REQ-028 Arithmetic is modulo 2^WIDTH.
REQ-029 SLT/SLTU return 1 or 0, zero-extended; SLT is signed, SLTU unsigned.
REQ-030 Shift amount is operandB[SHAMT_W-1:0]; upper bits are ignored; SRA sign-fills.
REQ-031 flagZero = (result == 0) for every op, including illegal.
REQ-032 flagNeg = result[WIDTH-1].
REQ-033 flagCarry on ADD = carry-out; on SUB = 1 iff A >= B unsigned; otherwise 0.
REQ-034 flagOverflow = signed overflow on ADD/SUB; otherwise 0.
REQ-035 An illegal opcode gives result=0, errIllegal=1, flagZero=1, estimatedPower=0, and it is not counted.
REQ-036 Power table: ADD 10, SUB 12, AND 8, OR 8, XOR 9, SLT 12, SLTU 12, SLL 20, SRL 20, SRA 22.
REQ-037 estimatedPower = 0 when S2 is empty.
REQ-038 One per-opcode counter per legal op plus operationTotal, each incremented at the acceptance edge.
REQ-039 All counters saturate at 2^CNT_W-1 and never wrap.
REQ-040 operationMostUsed is registered, updates the edge after the counter change, and breaks ties by the lowest opcode.
REQ-041 clearStats=1 zeroes all counters and operationMostUsed at that edge.
REQ-042 clearStats has priority over a same-edge acceptance, so that op is not counted; the pipeline is unaffected.
REQ-043 operationActive = S1valid || S2valid.

Reset
REQ-044 reset=0 asynchronously clears S1valid, S2valid and all counters.
REQ-045 During reset, all outputs read 0, including inReady, which is forced to 0 while reset=0.
REQ-046 An in-flight operation during reset is discarded and never presented.
REQ-047 The first acceptance is possible at the first rising edge after reset deasserts.

Verification
REQ-048 WIDTH=32; ADD 0xFFFFFFFF+1 -> result 0, flagZero=1, flagCarry=1, flagOverflow=0, power 10, two edges after acceptance.
REQ-049 SUB 0x80000000-1 -> 0x7FFFFFFF, flagOverflow=1, flagCarry=1; SRA 0x80000000 by 0x24 -> 0xF8000000 (shift 4).
REQ-050 Back-to-back 4 ops with outReady=0 for 3 cycles -> S2 and S1 hold, inReady=0, no op lost or duplicated, order preserved.
REQ-051 5x ADD then 5x SUB -> operationTotal=10, operationMostUsed=0 (tie goes low); a further SUB -> mostUsed=1 one edge later.
REQ-052 op=12 -> errIllegal=1, result 0, power 0, operationTotal unchanged; clearStats on the same edge as an accepted ADD -> total 0.
REQ-053 Assert reset mid-stream with 2 ops in flight -> outValid=0 and operationTotal=0 immediately; no stale output after release; WIDTH=16 rerun of REQ-048 with 0xFFFF+1.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage ALU with valid/ready handshake, result flags,
// a per-operation power estimate and saturating usage statistics.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [3:0]       op,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             flagZero,
  output logic             flagNeg,
  output logic             flagCarry,
  output logic             flagOverflow,
  output logic             errIllegal,
  input  logic             clearStats,
  output logic [CNT_W-1:0] operationTotal,
  output logic [3:0]       operationMostUsed,
  output logic [7:0]       estimatedPower,
  output logic             operationActive
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int NUM_OPS = 10;
  localparam int MSB     = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // stage 1: captured operands
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_op;

  // stage 2: finished result
  logic             s2_valid;
  logic [WIDTH-1:0] s2_res;
  logic             s2_zero;
  logic             s2_neg;
  logic             s2_carry;
  logic             s2_ovf;
  logic             s2_err;
  logic [7:0]       s2_pwr;

  logic s2_adv;
  logic accept;
  logic count_en;

  // ALU outputs computed from stage 1
  logic [WIDTH:0]       add_ext;
  logic [WIDTH-1:0]     sub_res;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry;
  logic                 alu_ovf;
  logic                 alu_err;
  logic [7:0]           alu_pwr;

  logic [CNT_W-1:0] op_cnt [NUM_OPS];
  logic [CNT_W-1:0] total_cnt;
  logic [3:0]       most_used;
  logic [3:0]       best_op;
  logic [CNT_W-1:0] best_cnt;

  // reset forces inReady low so nothing is taken while the block is held
  assign s2_adv   = !s2_valid || outReady;
  assign inReady  = reset && (!s1_valid || s2_adv);
  assign accept   = inValid && inReady;
  assign count_en = accept && (op < 4'(NUM_OPS));

  // stage 1 register: load on acceptance, empty when its op moves on
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= operandA;
      s1_b     <= operandB;
      s1_op    <= op;
    end else if (s1_valid && s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // ALU datapath, flags source and power lookup for the stage 1 op
  always_comb begin
    add_ext   = {1'b0, s1_a} + {1'b0, s1_b};
    sub_res   = s1_a - s1_b;
    shamt     = s1_b[SHAMT_W-1:0];
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    alu_pwr   = 8'd0;
    case (s1_op)
      OP_ADD: begin
        alu_res   = add_ext[WIDTH-1:0];
        alu_carry = add_ext[WIDTH];
        alu_ovf   = (s1_a[MSB] == s1_b[MSB]) && (add_ext[MSB] != s1_a[MSB]);
        alu_pwr   = 8'd10;
      end
      OP_SUB: begin
        alu_res   = sub_res;
        alu_carry = (s1_a >= s1_b);
        alu_ovf   = (s1_a[MSB] != s1_b[MSB]) && (sub_res[MSB] != s1_a[MSB]);
        alu_pwr   = 8'd12;
      end
      OP_AND: begin
        alu_res = s1_a & s1_b;
        alu_pwr = 8'd8;
      end
      OP_OR: begin
        alu_res = s1_a | s1_b;
        alu_pwr = 8'd8;
      end
      OP_XOR: begin
        alu_res = s1_a ^ s1_b;
        alu_pwr = 8'd9;
      end
      OP_SLT: begin
        alu_res[0] = ($signed(s1_a) < $signed(s1_b));
        alu_pwr    = 8'd12;
      end
      OP_SLTU: begin
        alu_res[0] = (s1_a < s1_b);
        alu_pwr    = 8'd12;
      end
      OP_SLL: begin
        alu_res = s1_a << shamt;
        alu_pwr = 8'd20;
      end
      OP_SRL: begin
        alu_res = s1_a >> shamt;
        alu_pwr = 8'd20;
      end
      OP_SRA: begin
        alu_res = WIDTH'($signed(s1_a) >>> shamt);
        alu_pwr = 8'd22;
      end
      default: begin
        alu_err = 1'b1;
      end
    endcase
  end

  // stage 2 register: refills whenever the output side can advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_zero  <= 1'b0;
      s2_neg   <= 1'b0;
      s2_carry <= 1'b0;
      s2_ovf   <= 1'b0;
      s2_err   <= 1'b0;
      s2_pwr   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res   <= alu_res;
        s2_zero  <= (alu_res == '0);
        s2_neg   <= alu_res[MSB];
        s2_carry <= alu_carry;
        s2_ovf   <= alu_ovf;
        s2_err   <= alu_err;
        s2_pwr   <= alu_pwr;
      end
    end
  end

  // saturating usage counters, bumped at the acceptance edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OPS; i++) op_cnt[i] <= '0;
      total_cnt <= '0;
    end else if (clearStats) begin
      for (int i = 0; i < NUM_OPS; i++) op_cnt[i] <= '0;
      total_cnt <= '0;
    end else if (count_en) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if ((op == 4'(i)) && (op_cnt[i] != CNT_MAX)) op_cnt[i] <= op_cnt[i] + CNT_W'(1);
      end
      if (total_cnt != CNT_MAX) total_cnt <= total_cnt + CNT_W'(1);
    end
  end

  // highest counter wins; strict compare keeps the lowest opcode on ties
  always_comb begin
    best_op  = 4'd0;
    best_cnt = op_cnt[0];
    for (int i = 1; i < NUM_OPS; i++) begin
      if (op_cnt[i] > best_cnt) begin
        best_cnt = op_cnt[i];
        best_op  = 4'(i);
      end
    end
  end

  // most-used register trails the counters by one edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          most_used <= 4'd0;
    else if (clearStats) most_used <= 4'd0;
    else                 most_used <= best_op;
  end

  assign outValid          = s2_valid;
  assign result            = s2_res;
  assign flagZero          = s2_zero;
  assign flagNeg           = s2_neg;
  assign flagCarry         = s2_carry;
  assign flagOverflow      = s2_ovf;
  assign errIllegal        = s2_err;
  assign estimatedPower    = s2_valid ? s2_pwr : 8'd0;
  assign operationTotal    = total_cnt;
  assign operationMostUsed = most_used;
  assign operationActive   = s1_valid || s2_valid;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus hand sequences for stalls,
// statistics, illegal opcodes, mid-stream reset and a 16-bit instance.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        f_zero, f_neg, f_carry, f_ovf, err_ill;
  logic        clear_stats = 1'b0;
  logic [31:0] op_total;
  logic [3:0]  most_used;
  logic [7:0]  power;
  logic        active;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] op_a16 = '0;
  logic [15:0] op_b16 = '0;
  logic [3:0]  op16 = '0;
  logic        out_valid16;
  logic [15:0] result16;
  logic        f_zero16, f_neg16, f_carry16, f_ovf16, err_ill16;
  logic [15:0] op_total16;
  logic [3:0]  most_used16;
  logic [7:0]  power16;
  logic        active16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .inValid(in_valid), .inReady(in_ready),
    .operandA(op_a), .operandB(op_b), .op(op), .outValid(out_valid),
    .outReady(out_ready), .result(result), .flagZero(f_zero), .flagNeg(f_neg),
    .flagCarry(f_carry), .flagOverflow(f_ovf), .errIllegal(err_ill),
    .clearStats(clear_stats), .operationTotal(op_total),
    .operationMostUsed(most_used), .estimatedPower(power), .operationActive(active)
  );

  alu_pipe #(.WIDTH(16), .CNT_W(16)) dut16 (
    .clk(clk), .reset(reset), .inValid(in_valid16), .inReady(in_ready16),
    .operandA(op_a16), .operandB(op_b16), .op(op16), .outValid(out_valid16),
    .outReady(1'b1), .result(result16), .flagZero(f_zero16), .flagNeg(f_neg16),
    .flagCarry(f_carry16), .flagOverflow(f_ovf16), .errIllegal(err_ill16),
    .clearStats(1'b0), .operationTotal(op_total16),
    .operationMostUsed(most_used16), .estimatedPower(power16), .operationActive(active16)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z, n, c, v, err;
    logic [7:0]  pwr;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    op       = o;
    op_a     = a;
    op_b     = b;
  endtask

  initial begin
    int exp_total;
    int sent;
    int recv;

    vecs[0]  = '{4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd10};
    vecs[1]  = '{4'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd12};
    vecs[2]  = '{4'd9, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd22};
    vecs[3]  = '{4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd10};
    vecs[4]  = '{4'd1, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd12};
    vecs[5]  = '{4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd8};
    vecs[6]  = '{4'd3, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd8};
    vecs[7]  = '{4'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9};
    vecs[8]  = '{4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd12};
    vecs[9]  = '{4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd12};
    vecs[10] = '{4'd7, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd20};
    vecs[11] = '{4'd8, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd20};
    vecs[12] = '{4'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd12};
    vecs[13] = '{4'd12, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};

    // reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_power", power, 0);
    check("rst_total", op_total, 0);
    check("rst_most_used", most_used, 0);
    check("rst_active", active, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("post_rst_in_ready", in_ready, 1);

    // table vectors, one op at a time, result checked two edges after acceptance
    exp_total = 0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk);
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      check($sformatf("vec%0d_early_valid", i), out_valid, 0);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_result", i), result, vecs[i].res);
      check($sformatf("vec%0d_flags", i), {f_zero, f_neg, f_carry, f_ovf, err_ill},
            {vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v, vecs[i].err});
      check($sformatf("vec%0d_power", i), power, vecs[i].pwr);
      if (vecs[i].op < 4'd10) exp_total++;
      check($sformatf("vec%0d_total", i), op_total, exp_total);
    end
    @(negedge clk);
    check("idle_power", power, 0);

    // statistics clear, then 5 ADD + 5 SUB back-to-back
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    check("clear_total", op_total, 0);
    check("clear_most_used", most_used, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i < 5) ? 4'd0 : 4'd1, 32'(i), 32'd1);
      #1 check($sformatf("b2b_in_ready%0d", i), in_ready, 1);
      @(negedge clk);
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    check("tie_total", op_total, 10);
    @(negedge clk);
    check("tie_most_used", most_used, 0);
    drive(1'b1, 4'd1, 32'd9, 32'd1);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    check("sub6_total", op_total, 11);
    check("sub6_most_used_lag", most_used, 0);
    @(negedge clk);
    check("sub6_most_used", most_used, 1);

    // stall: 4 ops, outReady low for three cycles with both stages full
    sent = 0;
    recv = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      if (sent < 4) drive(1'b1, 4'd0, 32'(sent), 32'd100);
      else          drive(1'b0, 4'd0, 32'd0, 32'd0);
      #1;
      if (out_valid) begin
        check($sformatf("stall_result%0d_c%0d", recv, c), result, 100 + recv);
        if (out_ready) recv++;
        else check($sformatf("stall_in_ready_c%0d", c), in_ready, (sent - recv) < 2);
      end
      if (in_valid && in_ready) sent++;
      if (recv == 4) break;
    end
    check("stall_received", recv, 4);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    check("stall_total", op_total, 15);

    // illegal opcode is flagged and not counted
    @(negedge clk);
    drive(1'b1, 4'd12, 32'h1234, 32'h5678);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("ill_valid", out_valid, 1);
    check("ill_err", err_ill, 1);
    check("ill_result", result, 0);
    check("ill_zero", f_zero, 1);
    check("ill_power", power, 0);
    check("ill_total", op_total, 15);

    // clearStats beats a same-edge acceptance; op still flows through
    @(negedge clk);
    clear_stats = 1'b1;
    drive(1'b1, 4'd0, 32'd2, 32'd3);
    @(negedge clk);
    clear_stats = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    check("clr_acc_total", op_total, 0);
    @(negedge clk);
    check("clr_acc_valid", out_valid, 1);
    check("clr_acc_result", result, 5);
    check("clr_acc_total2", op_total, 0);
    check("clr_acc_most_used", most_used, 0);

    // reset with two ops in flight
    @(negedge clk);
    drive(1'b1, 4'd0, 32'd1, 32'd1);
    @(negedge clk);
    drive(1'b1, 4'd0, 32'd2, 32'd2);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    check("mid_pre_active", active, 1);
    check("mid_pre_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_total", op_total, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_active", active, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 4'd0, 32'd7, 32'd8);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    check("post_rst_no_stale", out_valid, 0);
    @(negedge clk);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_result", result, 15);
    check("post_rst_total", op_total, 1);
    @(negedge clk);
    check("post_rst_drained", out_valid, 0);

    // 16-bit instance
    in_valid16 = 1'b1; op16 = 4'd0; op_a16 = 16'hFFFF; op_b16 = 16'h0001;
    @(negedge clk);
    in_valid16 = 1'b1; op16 = 4'd9; op_a16 = 16'h8000; op_b16 = 16'h0014;
    @(negedge clk);
    in_valid16 = 1'b0;
    check("w16_add_valid", out_valid16, 1);
    check("w16_add_result", result16, 0);
    check("w16_add_flags", {f_zero16, f_carry16, f_ovf16}, 3'b110);
    check("w16_add_power", power16, 10);
    @(negedge clk);
    check("w16_sra_result", result16, 16'hF800);
    check("w16_sra_power", power16, 22);
    check("w16_total", op_total16, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
